// File: rtl/bitstream_reader.sv
// MSB-first bit unpacker: buffers 32-bit packed words and presents a 32-bit
// look-ahead window that downstream VLC decoders consume 1..32 bits at a time.
module bitstream_reader #(
  parameter int BUF_WIDTH  = 64,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  restart,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [WORD_WIDTH-1:0] peek_data,
  output logic [5:0]            peek_bits,
  input  logic                  consume_en,
  input  logic [5:0]            consume_bits,
  input  logic                  align_en,
  output logic [31:0]           bit_position,
  output logic                  underflow_err
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered fill, so the source may hold in_valid
  // and in_data stable until that edge without any combinational loop.

  logic [BUF_WIDTH-1:0] buf_q, buf_d;
  logic [6:0]           fill_q, fill_d;
  logic [31:0]          pos_q, pos_d;
  logic                 err_q, err_d;

  logic [BUF_WIDTH-1:0] buf_c;
  logic [6:0]           fill_c;
  logic [31:0]          pos_c;
  logic [2:0]           pad;
  logic                 accept;

  assign in_ready      = (fill_q <= 7'd32);
  assign peek_data     = buf_q[BUF_WIDTH-1 -: WORD_WIDTH];
  assign peek_bits     = (fill_q >= 7'd32) ? 6'd32 : fill_q[5:0];
  assign bit_position  = pos_q;
  assign underflow_err = err_q;
  assign accept        = in_valid && in_ready;

  always_comb begin
    buf_c  = buf_q;
    fill_c = fill_q;
    pos_c  = pos_q;
    err_d  = err_q;
    pad    = 3'd0;

    if (consume_en && (consume_bits != 6'd0)) begin
      if ((consume_bits > 6'd32) || ({1'b0, consume_bits} > fill_q)) begin
        err_d = 1'b1;
      end else begin
        buf_c  = buf_q << consume_bits;
        fill_c = fill_q - {1'b0, consume_bits};
        pos_c  = pos_q + {26'd0, consume_bits};
      end
    end

    // Distance to the next byte boundary of the post-consume position.
    pad = 3'd0 - pos_c[2:0];
    if (align_en && (pad != 3'd0)) begin
      if ({4'd0, pad} > fill_c) begin
        err_d = 1'b1;
      end else begin
        buf_c  = buf_c << pad;
        fill_c = fill_c - {4'd0, pad};
        pos_c  = pos_c + {29'd0, pad};
      end
    end

    // Bits below fill_c are always zero, so OR-ing the new word is a placement.
    if (accept) begin
      buf_c  = buf_c | ({in_data, {(BUF_WIDTH-WORD_WIDTH){1'b0}}} >> fill_c);
      fill_c = fill_c + 7'd32;
    end

    buf_d  = buf_c;
    fill_d = fill_c;
    pos_d  = pos_c;

    if (restart) begin
      buf_d  = '0;
      fill_d = 7'd0;
      pos_d  = 32'd0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_q  <= '0;
      fill_q <= 7'd0;
      pos_q  <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      pos_q  <= pos_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_bitstream_reader.sv
// Bench for bitstream_reader: directed scenarios plus random traffic checked
// against a bit-queue model of the stream.
module tb_bitstream_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        restart;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] peek_data;
  logic [5:0]  peek_bits;
  logic        consume_en;
  logic [5:0]  consume_bits;
  logic        align_en;
  logic [31:0] bit_position;
  logic        underflow_err;

  always #5 clock = ~clock;

  bitstream_reader dut (
    .clock         (clock),
    .reset         (reset),
    .restart       (restart),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .peek_data     (peek_data),
    .peek_bits     (peek_bits),
    .consume_en    (consume_en),
    .consume_bits  (consume_bits),
    .align_en      (align_en),
    .bit_position  (bit_position),
    .underflow_err (underflow_err)
  );

  // Reference model: the unconsumed stream as a queue of bits, first bit at front.
  bit          model_bits[$];
  logic [31:0] model_pos;
  logic        model_err;
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] model_peek();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++)
      if (i < model_bits.size()) v[31-i] = model_bits[i];
    return v;
  endfunction

  task automatic model_step(input bit rst, input bit rstrt, input bit cen, input int cb,
                            input bit aen, input bit iv, input logic [31:0] id);
    bit rdy;
    int pad;
    if (rst || rstrt) begin
      model_bits.delete();
      model_pos = '0;
      model_err = 1'b0;
    end else begin
      rdy = (model_bits.size() <= 32);
      if (cen && cb != 0) begin
        if (cb > 32 || cb > model_bits.size()) model_err = 1'b1;
        else begin
          for (int i = 0; i < cb; i++) void'(model_bits.pop_front());
          model_pos = model_pos + 32'(cb);
        end
      end
      pad = (8 - int'(model_pos % 8)) % 8;
      if (aen && pad != 0) begin
        if (pad > model_bits.size()) model_err = 1'b1;
        else begin
          for (int i = 0; i < pad; i++) void'(model_bits.pop_front());
          model_pos = model_pos + 32'(pad);
        end
      end
      if (iv && rdy)
        for (int i = 31; i >= 0; i--) model_bits.push_back(id[i]);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int nb;
    nb = (model_bits.size() >= 32) ? 32 : model_bits.size();
    chk({tag, ".in_ready"},  32'(in_ready),      32'(model_bits.size() <= 32));
    chk({tag, ".peek_data"}, peek_data,          model_peek());
    chk({tag, ".peek_bits"}, 32'(peek_bits),     32'(nb));
    chk({tag, ".bit_pos"},   bit_position,       model_pos);
    chk({tag, ".err"},       32'(underflow_err), 32'(model_err));
  endtask

  task automatic do_cycle(input string tag, input bit rst, input bit rstrt, input bit cen,
                          input int cb, input bit aen, input bit iv, input logic [31:0] id);
    reset        = rst;
    restart      = rstrt;
    consume_en   = cen;
    consume_bits = 6'(cb);
    align_en     = aen;
    in_valid     = iv;
    in_data      = id;
    @(posedge clock);
    #1;
    model_step(rst, rstrt, cen, cb, aen, iv, id);
    check_all(tag);
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; in_data = '0;
    consume_en = 1'b0; consume_bits = '0; align_en = 1'b0;
    model_bits.delete(); model_pos = '0; model_err = 1'b0;

    // Reset, word offered during reset is dropped
    do_cycle("rst0", 1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    do_cycle("rst1", 1, 0, 0, 0, 0, 0, 32'h0);
    chk("rst.peek_zero", peek_data, 32'h0);

    // First word visible next cycle
    do_cycle("load1", 0, 0, 0, 0, 0, 1, 32'hA5F0_1234);
    chk("load1.peek", peek_data, 32'hA5F0_1234);
    chk("load1.bits", 32'(peek_bits), 32'd32);
    do_cycle("load2", 0, 0, 0, 0, 0, 1, 32'hFFFF_0000);
    do_cycle("cons4", 0, 0, 1, 4, 0, 0, 32'h0);
    chk("cons4.peek", peek_data, 32'h5F01_234F);
    chk("cons4.pos", bit_position, 32'd4);
    chk("cons4.ready", 32'(in_ready), 32'd0);

    // Consume 3 then align to byte 1
    do_cycle("r_al", 0, 1, 0, 0, 0, 0, 32'h0);
    do_cycle("al_load", 0, 0, 0, 0, 0, 1, 32'hA5F0_1234);
    do_cycle("al_c3", 0, 0, 1, 3, 0, 0, 32'h0);
    do_cycle("al_go", 0, 0, 0, 0, 1, 0, 32'h0);
    chk("align.pos", bit_position, 32'd8);
    chk("align.topbyte", 32'(peek_data[31:24]), 32'h0000_00F0);

    // Underflow: fill 5, consume 6
    do_cycle("r_uf", 0, 1, 0, 0, 0, 0, 32'h0);
    do_cycle("uf_load", 0, 0, 0, 0, 0, 1, 32'h1357_9BDF);
    do_cycle("uf_c27", 0, 0, 1, 27, 0, 0, 32'h0);
    do_cycle("uf_c6", 0, 0, 1, 6, 0, 0, 32'h0);
    chk("uf.err", 32'(underflow_err), 32'd1);
    chk("uf.bits", 32'(peek_bits), 32'd5);
    do_cycle("uf_hold", 0, 0, 0, 0, 0, 0, 32'h0);
    chk("uf.sticky", 32'(underflow_err), 32'd1);
    do_cycle("uf_rst", 0, 1, 0, 0, 0, 1, 32'h1111_1111);
    chk("uf.clear", 32'(underflow_err), 32'd0);
    chk("uf.rst_bits", 32'(peek_bits), 32'd0);

    // Streaming 32 bits/cycle
    w = $urandom;
    exp_q.push_back(w);
    do_cycle("st_pre", 0, 0, 0, 0, 0, 1, w);
    for (int k = 0; k < 16; k++) begin
      w = $urandom;
      exp_q.push_back(w);
      do_cycle("stream", 0, 0, 1, 32, 0, 1, w);
      void'(exp_q.pop_front());
      chk("stream.sb_peek", peek_data, exp_q[0]);
      chk("stream.ready", 32'(in_ready), 32'd1);
    end
    chk("stream.pos", bit_position, 32'd512);
    exp_q.delete();

    // Consume + align + append in one cycle
    do_cycle("r_sim", 0, 1, 0, 0, 0, 0, 32'h0);
    do_cycle("sim_load", 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    do_cycle("sim_all", 0, 0, 1, 7, 1, 1, 32'h0000_00FF);
    chk("sim.pos", bit_position, 32'd8);
    chk("sim.peek", peek_data, 32'h3456_7800);
    chk("sim.ready", 32'(in_ready), 32'd0);
    do_cycle("sim_c24", 0, 0, 1, 24, 0, 0, 32'h0);
    chk("sim.appended", peek_data, 32'h0000_00FF);

    // consume_bits = 40 is illegal regardless of fill
    do_cycle("c40", 0, 0, 1, 40, 0, 0, 32'h0);
    chk("c40.err", 32'(underflow_err), 32'd1);
    chk("c40.pos", bit_position, 32'd32);
    chk("c40.peek", peek_data, 32'h0000_00FF);

    // Random traffic
    do_cycle("r_rand", 0, 1, 0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 400; k++) begin
      do_cycle("rand", 0, ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 19) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 24),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
